// File: rtl/servant_uart_rx.sv
// servant_uart_rx: 8N1 UART receiver with a first-word-fall-through byte FIFO.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module servant_uart_rx #(
    parameter int CLK_HZ     = 32000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overflow,
    input  logic       i_clear,
    output logic       o_busy
);

    localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT1_F  = (AW + 1)'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          push, ferr_set;
    logic          rx_meta, rx_s;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_n   = HALF_M1;
                    state_n = START;
                end
            end
            START: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_ONE;
                end else if (rx_s) begin
                    state_n = IDLE;
                end else begin
                    cnt_n     = DIV_M1;
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_ONE;
                end else begin
                    shift_n   = {rx_s, shift[7:1]};
                    cnt_n     = DIV_M1;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                // Returning to IDLE mid-stop-bit lets back-to-back frames start immediately.
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_ONE;
                end else if (rx_s) begin
                    push    = 1'b1;
                    state_n = IDLE;
                end else begin
                    ferr_set = 1'b1;
                    state_n  = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign o_busy = (state != IDLE);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          pop, full, push_ok, ovf_set;

    assign o_valid = (count != '0);
    assign full    = (count == DEPTH_C);
    assign pop     = o_valid && i_ready;
    assign push_ok = push && (!full || pop);
    assign ovf_set = push && full && !pop;
    // Gated so the head reads zero while empty, including straight out of reset.
    assign o_data  = o_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shift;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            o_frame_err <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT1_F;
                2'b01:   count <= count - CNT1_F;
                default: count <= count;
            endcase
            if (i_clear) begin
                o_frame_err <= 1'b0;
                o_overflow  <= 1'b0;
            end
            if (ferr_set) begin
                o_frame_err <= 1'b1;
            end
            if (ovf_set) begin
                o_overflow <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_servant_uart_rx.sv
// tb_servant_uart_rx: directed bench for servant_uart_rx at default parameters.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_servant_uart_rx;

    localparam int DIV = 278;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overflow;
    logic       clear;
    logic       busy;

    int tests = 0;
    int fails = 0;

    servant_uart_rx dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx        (rx),
        .o_data      (data),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_frame_err (frame_err),
        .o_overflow  (overflow),
        .i_clear     (clear),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_one();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Called just after a rising edge; stop_low > 0 holds the stop bit low that many bit times.
    task automatic send_byte(input logic [7:0] b, input int stop_low);
        rx = 1'b0;
        repeat (DIV) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) tick();
        end
        if (stop_low > 0) begin
            rx = 1'b0;
            repeat (stop_low * DIV) tick();
        end
        rx = 1'b1;
        repeat (DIV) tick();
    endtask

    initial begin
        int         lat;
        logic [7:0] got;
        logic [7:0] exp_q [8];

        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b0;
        clear = 1'b0;
        repeat (3) tick();
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow", overflow, 0);
        check("rst_data", data, 8'h00);
        rst_n = 1'b1;
        repeat (5) tick();

        // Single byte with latency measurement
        ready = 1'b1;
        lat   = 0;
        got   = 8'h00;
        fork
            send_byte(8'h55, 0);
            begin
                while (!valid && lat < 4000) begin
                    tick();
                    lat++;
                end
                got = data;
            end
        join
        ready = 1'b0;
        check("single_latency_ok", (lat >= 2642 && lat <= 2646), 1);
        check("single_data", got, 8'h55);
        check("single_popped", valid, 0);
        check("single_frame_err", frame_err, 0);

        // Framing error, then a clean byte
        send_byte(8'hA5, 2);
        check("ferr_set", frame_err, 1);
        check("ferr_no_push", valid, 0);
        check("ferr_idle", busy, 0);
        send_byte(8'h3C, 0);
        check("ferr_next_valid", valid, 1);
        check("ferr_next_data", data, 8'h3C);
        check("ferr_sticky", frame_err, 1);
        pop_one();
        check("ferr_empty", valid, 0);
        pulse_clear();
        check("ferr_cleared", frame_err, 0);

        // Glitch shorter than half a bit
        rx = 1'b0;
        repeat (50) tick();
        check("glitch_busy", busy, 1);
        repeat (50) tick();
        rx = 1'b1;
        repeat (100) tick();
        check("glitch_idle", busy, 0);
        check("glitch_no_push", valid, 0);
        send_byte(8'h81, 0);
        check("glitch_next_valid", valid, 1);
        check("glitch_next_data", data, 8'h81);
        pop_one();

        // Overflow: nine bytes into an eight-deep FIFO
        for (int i = 0; i < 9; i++) begin
            send_byte(8'(i), 0);
        end
        check("ovf_set", overflow, 1);
        check("ovf_count", dut.count, 8);
        check("ovf_head", data, 8'h00);
        check("ovf_no_ferr", frame_err, 0);
        pulse_clear();
        check("ovf_cleared", overflow, 0);

        // Full FIFO, pop coincident with the push of 0x09
        fork
            send_byte(8'h09, 0);
            begin
                repeat (2643) tick();
                ready = 1'b1;
                tick();
                ready = 1'b0;
            end
        join
        check("fullpop_no_ovf", overflow, 0);
        check("fullpop_count", dut.count, 8);
        check("fullpop_head", data, 8'h01);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09};
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_valid_%0d", i), valid, 1);
            check($sformatf("drain_data_%0d", i), data, exp_q[i]);
            pop_one();
        end
        check("drain_empty", valid, 0);

        // Reset during data bit 4 of 0xFF
        fork
            send_byte(8'hFF, 0);
            begin
                repeat (5 * DIV + 139) tick();
                check("midrst_busy_before", busy, 1);
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                check("midrst_busy", busy, 0);
                check("midrst_valid", valid, 0);
                check("midrst_frame_err", frame_err, 0);
                check("midrst_overflow", overflow, 0);
                check("midrst_data", data, 8'h00);
            end
        join
        repeat (20) tick();
        check("midrst_no_push", valid, 0);
        check("midrst_idle", busy, 0);
        send_byte(8'h42, 0);
        check("midrst_next_valid", valid, 1);
        check("midrst_next_data", data, 8'h42);
        pop_one();
        check("final_empty", valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
